// File: rtl/reconf_dsp_seq_pkg.sv
// reconf_dsp_seq_pkg: shared definitions for the reconf_dsp_seq microprogram
// sequencer. Holds the default geometry, the instruction field offsets and
// widths, the FSM state encoding and the NOP instruction word.
package reconf_dsp_seq_pkg;

  // Default geometry
  localparam int FIFO_PA_BITS_D = 5;
  localparam int FIFO_PD_BITS_D = 5;
  localparam int FIFO_PF_BITS_D = 5;
  localparam int CMD_WIDTH_D    = 3;
  localparam int PROG_BITS_D    = 5;
  localparam int DRAIN_CYCLES_D = 6;
  localparam int IW_D = FIFO_PA_BITS_D + FIFO_PD_BITS_D + FIFO_PF_BITS_D + CMD_WIDTH_D + 7;

  // Instruction field offsets, LSB up, for the default geometry
  localparam int OFF_FAA  = 0;
  localparam int OFF_FAD  = OFF_FAA + FIFO_PA_BITS_D;
  localparam int OFF_FAC  = OFF_FAD + FIFO_PD_BITS_D;
  localparam int OFF_CMD  = OFF_FAC + FIFO_PF_BITS_D;
  localparam int OFF_PA_L = OFF_CMD + CMD_WIDTH_D;
  localparam int OFF_PD_L = OFF_PA_L + 1;
  localparam int OFF_PC_L = OFF_PA_L + 2;
  localparam int OFF_PI_R = OFF_PA_L + 3;
  localparam int OFF_PP_L = OFF_PA_L + 4;
  localparam int OFF_OMUX = OFF_PA_L + 5;
  localparam int OFF_EOP  = OFF_PA_L + 6;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // All strobes low, no input pull, no end-of-program
  localparam logic [IW_D-1:0] NOP_INSTR = {IW_D{1'b0}};

endpackage

// File: rtl/reconf_dsp_seq_imem.sv
// reconf_dsp_seq_imem: program memory, one synchronous write port and one
// asynchronous read port (distributed RAM). Contents are not reset.
module reconf_dsp_seq_imem
  import reconf_dsp_seq_pkg::*;
#(
  parameter int AW = PROG_BITS_D,
  parameter int DW = IW_D
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/reconf_dsp_seq.sv
// reconf_dsp_seq: steps a loaded microprogram one instruction per accepted
// cycle, stalls with the element on input starvation, loops until stopped and
// drains the DSP pipeline before signalling done.
// Optional build macro RECONF_DSP_SEQ_PASSLIM_EN adds a pass_limit input.
module reconf_dsp_seq
  import reconf_dsp_seq_pkg::*;
#(
  parameter int FIFO_PA_BITS = FIFO_PA_BITS_D,
  parameter int FIFO_PD_BITS = FIFO_PD_BITS_D,
  parameter int FIFO_PF_BITS = FIFO_PF_BITS_D,
  parameter int CMD_WIDTH    = CMD_WIDTH_D,
  parameter int PROG_BITS    = PROG_BITS_D,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_D,
  parameter int IW = FIFO_PA_BITS + FIFO_PD_BITS + FIFO_PF_BITS + CMD_WIDTH + 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [PROG_BITS-1:0]    cfg_addr,
  input  logic [IW-1:0]           cfg_data,
  output logic                    cfg_err,
  input  logic                    start,
  input  logic                    stop,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             pass_cnt,
`ifdef RECONF_DSP_SEQ_PASSLIM_EN
  input  logic [15:0]             pass_limit,
`endif
  input  logic                    din_valid,
  output logic [FIFO_PA_BITS-1:0] exe_faa,
  output logic [FIFO_PD_BITS-1:0] exe_fad,
  output logic [FIFO_PF_BITS-1:0] exe_fac,
  output logic                    exe_pa_l,
  output logic                    exe_pd_l,
  output logic                    exe_pc_l,
  output logic                    exe_pi_r,
  output logic                    exe_pp_l,
  output logic                    exe_cfg_omux,
  output logic [CMD_WIDTH-1:0]    exe_cmd
);

  // Field offsets for this instance's geometry
  localparam int O_FAD  = FIFO_PA_BITS;
  localparam int O_FAC  = O_FAD + FIFO_PD_BITS;
  localparam int O_CMD  = O_FAC + FIFO_PF_BITS;
  localparam int O_PA_L = O_CMD + CMD_WIDTH;
  localparam int O_PI_R = O_PA_L + 3;
  localparam int O_EOP  = O_PA_L + 6;
  localparam int CNT_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  seq_state_e           state_r, state_s;
  logic [PROG_BITS-1:0] pc_r, pc_s, rd_addr_s;
  logic [IW-1:0]        ir_r, ir_s, rd_data_s;
  logic [15:0]          pass_cnt_r, pass_cnt_s;
  logic                 stop_pend_r, stop_pend_s;
  logic [CNT_W-1:0]     drain_cnt_r, drain_cnt_s;
  logic                 cfg_err_r, cfg_err_s;
  logic                 done_r, done_s;
  logic                 mem_we_s, adv_s, lim_hit_s;

  reconf_dsp_seq_imem #(.AW(PROG_BITS), .DW(IW)) u_imem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // Next fetch address: sequential successor, or the top of the program at a
  // boundary and while idle (start always begins at address 0)
  assign rd_addr_s = (state_r == ST_RUN && !ir_r[O_EOP]) ? pc_r + PROG_BITS'(1)
                                                         : {PROG_BITS{1'b0}};
  // The element consumes the instruction unless it pulls input that is absent
  assign adv_s = ~ir_r[O_PI_R] | din_valid;

`ifdef RECONF_DSP_SEQ_PASSLIM_EN
  logic [15:0] pass_limit_r;

  // Capture the pass limit at start; zero means no limit
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_limit_r <= 16'd0;
    end else if (state_r == ST_IDLE && start) begin
      pass_limit_r <= pass_limit;
    end else begin
      pass_limit_r <= pass_limit_r;
    end
  end

  assign lim_hit_s = (pass_limit_r != 16'd0) && ((pass_cnt_r + 16'd1) == pass_limit_r);
`else
  assign lim_hit_s = 1'b0;
`endif

  // Next-state and datapath decisions of the sequencer FSM
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    ir_s        = ir_r;
    pass_cnt_s  = pass_cnt_r;
    stop_pend_s = stop_pend_r;
    drain_cnt_s = drain_cnt_r;
    cfg_err_s   = 1'b0;
    done_s      = 1'b0;
    mem_we_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mem_we_s = cfg_we;
        if (start) begin
          state_s     = ST_RUN;
          pc_s        = {PROG_BITS{1'b0}};
          ir_s        = rd_data_s;
          pass_cnt_s  = 16'd0;
          stop_pend_s = stop;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        cfg_err_s   = cfg_we;
        stop_pend_s = stop_pend_r | stop;
        if (!adv_s) begin
          ir_s = ir_r;
        end else if (ir_r[O_EOP]) begin
          pass_cnt_s = pass_cnt_r + 16'd1;
          if (stop_pend_r || stop || lim_hit_s) begin
            // Issue NOPs from here on so the DSP pipeline empties
            state_s     = ST_DRAIN;
            drain_cnt_s = CNT_W'(DRAIN_CYCLES - 1);
            ir_s        = IW'(NOP_INSTR);
            stop_pend_s = 1'b0;
          end else begin
            pc_s = {PROG_BITS{1'b0}};
            ir_s = rd_data_s;
          end
        end else begin
          pc_s = pc_r + PROG_BITS'(1);
          ir_s = rd_data_s;
        end
      end
      ST_DRAIN: begin
        cfg_err_s = cfg_we;
        if (drain_cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          drain_cnt_s = drain_cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        ir_s    = IW'(NOP_INSTR);
      end
    endcase
  end

  // Sequencer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pc_r        <= {PROG_BITS{1'b0}};
      ir_r        <= {IW{1'b0}};
      pass_cnt_r  <= 16'd0;
      stop_pend_r <= 1'b0;
      drain_cnt_r <= {CNT_W{1'b0}};
      cfg_err_r   <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      ir_r        <= ir_s;
      pass_cnt_r  <= pass_cnt_s;
      stop_pend_r <= stop_pend_s;
      drain_cnt_r <= drain_cnt_s;
      cfg_err_r   <= cfg_err_s;
      done_r      <= done_s;
    end
  end

  // ir holds NOP outside RUN, so the bundle comes straight from the register
  assign exe_faa      = ir_r[0 +: FIFO_PA_BITS];
  assign exe_fad      = ir_r[O_FAD +: FIFO_PD_BITS];
  assign exe_fac      = ir_r[O_FAC +: FIFO_PF_BITS];
  assign exe_cmd      = ir_r[O_CMD +: CMD_WIDTH];
  assign exe_pa_l     = ir_r[O_PA_L];
  assign exe_pd_l     = ir_r[O_PA_L + 1];
  assign exe_pc_l     = ir_r[O_PA_L + 2];
  assign exe_pi_r     = ir_r[O_PI_R];
  assign exe_pp_l     = ir_r[O_PA_L + 4];
  assign exe_cfg_omux = ir_r[O_PA_L + 5];

  assign busy     = (state_r != ST_IDLE);
  assign done     = done_r;
  assign cfg_err  = cfg_err_r;
  assign pass_cnt = pass_cnt_r;

endmodule

// File: tb/tb_reconf_dsp_seq.sv
// tb_reconf_dsp_seq: self-checking bench for reconf_dsp_seq with a
// program-level reference model stepped alongside the design.
module tb_reconf_dsp_seq;
  import reconf_dsp_seq_pkg::*;

  localparam int DEPTH = 2**PROG_BITS_D;
  localparam int EW    = IW_D - 1;

  logic clk = 1'b0;
  logic rst, cfg_we, start, stop, din_valid;
  logic [PROG_BITS_D-1:0] cfg_addr;
  logic [IW_D-1:0] cfg_data;
  logic cfg_err, busy, done;
  logic [15:0] pass_cnt;
`ifdef RECONF_DSP_SEQ_PASSLIM_EN
  logic [15:0] pass_limit;
`endif
  logic [FIFO_PA_BITS_D-1:0] exe_faa;
  logic [FIFO_PD_BITS_D-1:0] exe_fad;
  logic [FIFO_PF_BITS_D-1:0] exe_fac;
  logic exe_pa_l, exe_pd_l, exe_pc_l, exe_pi_r, exe_pp_l, exe_cfg_omux;
  logic [CMD_WIDTH_D-1:0] exe_cmd;

  // Reference model: program image, program index, passes, stop request
  logic [IW_D-1:0] mem_m [DEPTH];
  int m_mode;          // 0 idle, 1 running, 2 draining
  int m_idx;
  int m_left;
  logic [15:0] m_pass, m_lim;
  bit m_stopq, m_done, m_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [IW_D-1:0] prog0, prog1;

  reconf_dsp_seq dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .start(start), .stop(stop), .busy(busy), .done(done),
    .pass_cnt(pass_cnt),
`ifdef RECONF_DSP_SEQ_PASSLIM_EN
    .pass_limit(pass_limit),
`endif
    .din_valid(din_valid), .exe_faa(exe_faa), .exe_fad(exe_fad), .exe_fac(exe_fac),
    .exe_pa_l(exe_pa_l), .exe_pd_l(exe_pd_l), .exe_pc_l(exe_pc_l), .exe_pi_r(exe_pi_r),
    .exe_pp_l(exe_pp_l), .exe_cfg_omux(exe_cfg_omux), .exe_cmd(exe_cmd)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] dut_exe();
    return {exe_cfg_omux, exe_pp_l, exe_pi_r, exe_pc_l, exe_pd_l, exe_pa_l,
            exe_cmd, exe_fac, exe_fad, exe_faa};
  endfunction

  function automatic logic [EW+18:0] dut_obs();
    return {busy, done, cfg_err, pass_cnt, dut_exe()};
  endfunction

  function automatic logic [EW+18:0] exp_obs();
    logic [IW_D-1:0] w;
    logic [EW-1:0] e;
    w = mem_m[m_idx];
    e = (m_mode == 1) ? w[EW-1:0] : {EW{1'b0}};
    return {(m_mode != 0), m_done, m_err, m_pass, e};
  endfunction

  function automatic logic [IW_D-1:0] rnd_instr(bit pi, bit eop);
    logic [IW_D-1:0] w;
    w = IW_D'({$urandom, $urandom});
    w[OFF_PI_R] = pi;
    w[OFF_EOP]  = eop;
    return w;
  endfunction

  // One clock edge: advance the model from the inputs seen at that edge
  task automatic step();
    logic [IW_D-1:0] cur;
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_idx = 0; m_pass = 16'd0; m_stopq = 1'b0;
      m_left = 0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = cfg_we && (m_mode != 0);
      case (m_mode)
        0: begin
          if (start) begin
            m_mode = 1; m_idx = 0; m_pass = 16'd0; m_stopq = stop;
`ifdef RECONF_DSP_SEQ_PASSLIM_EN
            m_lim = pass_limit;
`else
            m_lim = 16'd0;
`endif
          end
          if (cfg_we) mem_m[cfg_addr] = cfg_data;
        end
        1: begin
          cur = mem_m[m_idx];
          m_stopq = m_stopq | stop;
          if (!cur[OFF_PI_R] || din_valid) begin
            if (cur[OFF_EOP]) begin
              m_pass = m_pass + 16'd1;
              if (m_stopq || (m_lim != 16'd0 && m_pass == m_lim)) begin
                m_mode = 2; m_left = DRAIN_CYCLES_D;
              end else begin
                m_idx = 0;
              end
            end else begin
              m_idx = (m_idx + 1) % DEPTH;
            end
          end
        end
        2: begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_mode = 0; m_done = 1'b1; end
        end
        default: m_mode = 0;
      endcase
    end
    #1;
  endtask

  task automatic load(int addr, logic [IW_D-1:0] data);
    cfg_we = 1'b1; cfg_addr = PROG_BITS_D'(addr); cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_tests++;
    if ({busy, done, cfg_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b required=000", {busy, done, cfg_err});
    end
    n_tests++;
    if (pass_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_pass_cnt got=%0d required=0", pass_cnt);
    end
    n_tests++;
    if (dut_exe() !== {EW{1'b0}}) begin
      n_fail++; $display("FAIL reset_exe got=%h required=0", dut_exe());
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int ndone = 0;
    int nnop = 0;
    din_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      start = (c == 0); stop = (c == 5);
      step();
      n_tests++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++; $display("FAIL basic cyc=%0d got=%h required=%h", c, dut_obs(), exp_obs());
      end
      if (done === 1'b1) ndone++;
      if (busy === 1'b1 && dut_exe() === {EW{1'b0}}) nnop++;
      if (m_mode == 0) break;
    end
    start = 1'b0; stop = 1'b0;
    n_tests++;
    if (pass_cnt !== 16'd3) begin
      n_fail++; $display("FAIL basic_passes got=%0d required=3", pass_cnt);
    end
    n_tests++;
    if (ndone != 1 || nnop != 6 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain done_pulses=%0d nop_cycles=%0d busy=%b required 1/6/0", ndone, nnop, busy);
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 60; c++) begin
      start = (c == 0); stop = (c == 6);
      din_valid = !(c >= 1 && c <= 4);
      step();
      n_tests++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++; $display("FAIL stall cyc=%0d got=%h required=%h", c, dut_obs(), exp_obs());
      end
      if (c >= 1 && c <= 4) begin
        n_tests++;
        if (dut_exe() !== prog0[EW-1:0]) begin
          n_fail++; $display("FAIL stall_hold cyc=%0d got=%h required=%h", c, dut_exe(), prog0[EW-1:0]);
        end
      end
      if (c == 5) begin
        n_tests++;
        if (dut_exe() !== prog1[EW-1:0]) begin
          n_fail++; $display("FAIL stall_resume got=%h required=%h", dut_exe(), prog1[EW-1:0]);
        end
      end
      if (m_mode == 0) break;
    end
    start = 1'b0; stop = 1'b0; din_valid = 1'b1;
    n_tests++;
    if (pass_cnt !== 16'd1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_end pass_cnt=%0d busy=%b required 1/0", pass_cnt, busy);
    end
  endtask

  task automatic test_start_stop();
    int ndone = 0;
    for (int c = 0; c < 40; c++) begin
      start = (c == 0); stop = (c == 0);
      step();
      n_tests++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++; $display("FAIL start_stop cyc=%0d got=%h required=%h", c, dut_obs(), exp_obs());
      end
      if (done === 1'b1) ndone++;
      if (m_mode == 0) break;
    end
    start = 1'b0; stop = 1'b0;
    n_tests++;
    if (pass_cnt !== 16'd1 || ndone != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_stop_end pass_cnt=%0d done_pulses=%0d busy=%b required 1/1/0", pass_cnt, ndone, busy);
    end
  endtask

  task automatic test_cfg_run();
    bit drain_hit = 1'b0;
    for (int c = 0; c < 60; c++) begin
      start = (c == 0); stop = (c == 4);
      cfg_we = (c == 2) || (m_mode == 2 && !drain_hit);
      if (m_mode == 2) drain_hit = 1'b1;
      cfg_addr = (c == 2) ? PROG_BITS_D'(1) : PROG_BITS_D'(0);
      cfg_data = ~prog1;
      step();
      n_tests++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++; $display("FAIL cfg_run cyc=%0d got=%h required=%h", c, dut_obs(), exp_obs());
      end
      if (c == 2) begin
        n_tests++;
        if (cfg_err !== 1'b1) begin
          n_fail++; $display("FAIL cfg_err_pulse got=%b required=1", cfg_err);
        end
      end
      if (m_mode == 0) break;
    end
    cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
    // Rerun: the program must be the one loaded before the dropped writes
    for (int c = 0; c < 40; c++) begin
      start = (c == 0); stop = (c == 0);
      step();
      n_tests++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++; $display("FAIL cfg_rerun cyc=%0d got=%h required=%h", c, dut_obs(), exp_obs());
      end
      if (c == 1) begin
        n_tests++;
        if (dut_exe() !== prog1[EW-1:0]) begin
          n_fail++; $display("FAIL cfg_preserved got=%h required=%h", dut_exe(), prog1[EW-1:0]);
        end
      end
      if (m_mode == 0) break;
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 20 && m_pass != 16'd2; c++) step();
    n_tests++;
    if (pass_cnt !== 16'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre pass_cnt=%0d busy=%b required 2/1", pass_cnt, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if ({busy, done, cfg_err, pass_cnt, dut_exe()} !== {3'b000, 16'd0, {EW{1'b0}}}) begin
      n_fail++; $display("FAIL rstmid_post got=%h required=0", dut_obs());
    end
    for (int c = 0; c < 40; c++) begin
      start = (c == 0); stop = (c == 0);
      step();
      n_tests++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++; $display("FAIL rstmid_restart cyc=%0d got=%h required=%h", c, dut_obs(), exp_obs());
      end
      if (m_mode == 0) break;
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_wrap();
    for (int a = 0; a < DEPTH; a++) load(a, rnd_instr(1'($urandom), 1'b0));
    din_valid = 1'b1;
    for (int c = 0; c < 2 * DEPTH + 10; c++) begin
      start = (c == 0); stop = (c >= 3);
      step();
      n_tests++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++; $display("FAIL wrap cyc=%0d got=%h required=%h", c, dut_obs(), exp_obs());
      end
    end
    start = 1'b0; stop = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || pass_cnt !== 16'd0) begin
      n_fail++; $display("FAIL wrap_no_exit busy=%b pass_cnt=%0d required 1/0", busy, pass_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int len = $urandom_range(1, 6);
      int stop_at = $urandom_range(0, 30);
      for (int a = 0; a < len; a++) load(a, rnd_instr(1'($urandom), a == len - 1));
      for (int c = 0; c < 400; c++) begin
        start     = (c == 0) ? 1'b1 : ((m_mode != 0) && ($urandom_range(0, 7) == 0));
        stop      = (c >= stop_at);
        din_valid = ($urandom_range(0, 9) < 7);
        cfg_we    = (c > 0) && ($urandom_range(0, 9) == 0);
        cfg_addr  = PROG_BITS_D'($urandom);
        cfg_data  = rnd_instr(1'($urandom), 1'($urandom));
        step();
        n_tests++;
        if (dut_obs() !== exp_obs()) begin
          n_fail++; $display("FAIL random it=%0d cyc=%0d got=%h required=%h", it, c, dut_obs(), exp_obs());
        end
        if (c > 0 && m_mode == 0) break;
      end
      start = 1'b0; stop = 1'b0; cfg_we = 1'b0; din_valid = 1'b1;
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL random_timeout it=%0d busy=%b required=0", it, busy);
      end
    end
  endtask

`ifdef RECONF_DSP_SEQ_PASSLIM_EN
  task automatic test_pass_limit();
    int ndone = 0;
    load(0, prog0); load(1, prog1);
    pass_limit = 16'd4; din_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      start = (c == 0);
      step();
      n_tests++;
      if (dut_obs() !== exp_obs()) begin
        n_fail++; $display("FAIL passlim cyc=%0d got=%h required=%h", c, dut_obs(), exp_obs());
      end
      if (done === 1'b1) ndone++;
      if (m_mode == 0) break;
    end
    start = 1'b0; pass_limit = 16'd0;
    n_tests++;
    if (pass_cnt !== 16'd4 || ndone != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL passlim_end pass_cnt=%0d done_pulses=%0d busy=%b required 4/1/0", pass_cnt, ndone, busy);
    end
  endtask
`endif

  // Test sequence
  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0; din_valid = 1'b1;
    m_lim = 16'd0;
`ifdef RECONF_DSP_SEQ_PASSLIM_EN
    pass_limit = 16'd0;
`endif
    prog0 = '0;
    prog0[OFF_FAA +: FIFO_PA_BITS_D] = 5'd1;
    prog0[OFF_PA_L] = 1'b1;
    prog0[OFF_PI_R] = 1'b1;
    prog1 = '0;
    prog1[OFF_CMD +: CMD_WIDTH_D] = 3'd2;
    prog1[OFF_PP_L] = 1'b1;
    prog1[OFF_EOP]  = 1'b1;

    test_reset();
    for (int a = 0; a < DEPTH; a++) load(a, rnd_instr(1'b0, 1'b0));
    load(0, prog0);
    load(1, prog1);
    test_basic();
    test_stall();
    test_start_stop();
    test_cfg_run();
    test_reset_mid();
`ifdef RECONF_DSP_SEQ_PASSLIM_EN
    test_pass_limit();
`endif
    test_wrap();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reconf_dsp_seq.md
Name: reconf_dsp_seq

Overview:
Microprogram sequencer that drives the execution/control bundle of one reconfigurable DSP element (FIFO tap addresses, load strobes, input pull, push, DSP opcode, output mux).
- Holds a small program loaded over a config port and steps it one instruction per accepted cycle.
- Stalls on input starvation exactly as the element does, and loops the program until stopped.
- Drains the DSP pipeline before reporting done.
- Sits between the host/CSR fabric and reconf_dsp_elem.

Parameters:
FIFO_PA_BITS, 5, width of exe_faa
FIFO_PD_BITS, 5, width of exe_fad
FIFO_PF_BITS, 5, width of exe_fac
CMD_WIDTH, 3, width of exe_cmd
PROG_BITS, 5, program memory address width (depth 2^PROG_BITS)
DRAIN_CYCLES, 6, NOP cycles issued after last pass (DSP stages + FIFO pipeline)
IW, FIFO_PA_BITS+FIFO_PD_BITS+FIFO_PF_BITS+CMD_WIDTH+7, instruction width (derived, do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_we  in  1  program memory write strobe
cfg_addr  in  PROG_BITS  write address
cfg_data  in  IW  instruction word
cfg_err  out  1  one-cycle pulse: write attempted while not IDLE (write dropped)
start  in  1  begin execution at address 0
stop  in  1  request stop at next program boundary
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on DRAIN->IDLE
pass_cnt  out  16  completed program passes since start, wraps
din_valid  in  1  element input valid (same net the element sees)
exe_faa/exe_fad/exe_fac  out  FIFO_Px_BITS  tap addresses
exe_pa_l, exe_pd_l, exe_pc_l, exe_pi_r, exe_pp_l, exe_cfg_omux  out  1 each  element strobes
exe_cmd  out  CMD_WIDTH  DSP opcode

Behaviour:
- Instruction fields, LSB up: faa, fad, fac, cmd, pa_l, pd_l, pc_l, pi_r, pp_l, omux, eop.
- States: IDLE, RUN, DRAIN. Reset -> IDLE. Reset clears pc=0, ir=0, pass_cnt=0, stop_pend=0, drain counter=0, cfg_err=0, done=0, and all exe_* to 0. Program memory is not reset.
- IDLE:
  - exe_* = 0 (NOP; exe_pi_r=0, so the element takes no input).
  - cfg_we writes mem[cfg_addr].
  - start -> RUN: ir<=mem[0], pc<=0, pass_cnt<=0, stop_pend<=stop.
- RUN:
  - exe_* driven combinationally from ir fields.
  - adv = ~ir.pi_r | din_valid. If adv=0, ir and pc hold and outputs stay stable (the element holds too).
  - On adv with ir.eop=0: pc<=pc+1, ir<=mem[pc+1]. Address wrap at 2^PROG_BITS-1 goes to 0.
  - On adv with ir.eop=1: pass_cnt++ and boundary reached. If stop_pend or stop, go to DRAIN with cnt<=DRAIN_CYCLES-1. Otherwise pc<=0, ir<=mem[0].
  - stop sets stop_pend in any RUN cycle.
  - cfg_we -> cfg_err pulse next cycle; memory unchanged.
- DRAIN: exe_*=0. Counter decrements each cycle. At 0 -> IDLE with done pulse. start is ignored. cfg_we -> cfg_err.
- start while busy: ignored.
- start and stop in the same IDLE cycle: exactly one pass, then drain.
- Program memory read is asynchronous (distributed RAM). Instruction latency is one cycle from adv to new outputs; the first instruction appears the cycle after start.
- Reset mid-RUN/DRAIN: IDLE next cycle, no done pulse, outputs NOP.
- Program without eop: runs through the wrap to 0 indefinitely. stop never takes effect; only rst exits.

Optional Feature:
RECONF_DSP_SEQ_PASSLIM_EN
- With the macro: adds input pass_limit[15:0], sampled at start. RUN treats the boundary where pass_cnt+1==pass_limit as stop. pass_limit=0 means unlimited.
- Without the macro: no port; stop is the only exit.

Decomposition:
- Shared package/header reconf_dsp_seq_defs holds:
  - instruction field offsets and widths;
  - state encodings (IDLE=0, RUN=1, DRAIN=2);
  - the NOP instruction constant.
- One sub-module, reconf_dsp_seq_imem: 2^PROG_BITS x IW write-port/async-read-port RAM.

Test Plan:
- Program {faa=1,pa_l=1,pi_r=1,cmd=0},{pp_l=1,cmd=2,eop=1}, din_valid=1, start then stop at cycle 5 -> exe pattern alternates each cycle; pass_cnt ends at 3; 6 NOP cycles; done pulse; busy falls with done.
- Same program, din_valid low for 4 cycles on instruction 0 -> exe_* held 4 cycles; pc does not advance; resumes on din_valid=1.
- start and stop asserted in the same cycle -> exactly one pass (pass_cnt=1), then drain and done.
- cfg_we during RUN -> cfg_err pulse; readback behaviour unchanged; memory word preserved after return to IDLE.
- rst asserted during RUN at pass 2 -> next cycle busy=0, exe_*=0, pass_cnt=0, no done. Restart runs the unchanged program.
- With RECONF_DSP_SEQ_PASSLIM_EN, pass_limit=4, no stop -> pass_cnt reaches 4, then drain and done.
